mem_lsu: RTL and testbench

- Load/store initiator between the MEM pipeline stage and the data port of the unified memory.
- Accepts one request at a time from the pipeline over a valid/ready handshake.
- Drives the memory's address, write data, size, sign, write and enable inputs, then captures the formatted read data one cycle after the enable pulse.
- Returns a response with an error flag for misaligned or out-of-range accesses.

---
 rtl/mem_lsu_if.sv | 46 ++++
 rtl/mem_lsu.sv | 212 +++++++++++++++++++++
 tb/tb_mem_lsu.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// Request/response and memory-port signal bundle for mem_lsu.
// Latency: none (wires only).
// Backpressure: carries reqValid/reqReady and rspValid/rspReady.
interface mem_lsu_if;
  // pipeline request channel
  logic        i_reqValid;
  logic        o_reqReady;
  logic [31:0] i_reqAddr;
  logic [31:0] i_reqWData;
  logic [1:0]  i_reqSize;
  logic        i_reqSign;
  logic        i_reqWrite;
  // pipeline response channel
  logic        o_rspValid;
  logic        i_rspReady;
  logic [31:0] o_rspData;
  logic        o_rspErr;
  // memory data port
  logic [31:0] o_memAddr;
  logic [31:0] o_memWData;
  logic [1:0]  o_memSize;
  logic        o_memSign;
  logic        o_memWrite;
  logic        o_memEn;
  logic [31:0] i_memRData;

  // LSU side
  modport master (
    input  i_reqValid, i_reqAddr, i_reqWData, i_reqSize, i_reqSign, i_reqWrite,
    output o_reqReady,
    output o_rspValid, o_rspData, o_rspErr,
    input  i_rspReady,
    output o_memAddr, o_memWData, o_memSize, o_memSign, o_memWrite, o_memEn,
    input  i_memRData
  );

  // pipeline + memory side
  modport slave (
    output i_reqValid, i_reqAddr, i_reqWData, i_reqSize, i_reqSign, i_reqWrite,
    input  o_reqReady,
    input  o_rspValid, o_rspData, o_rspErr,
    output i_rspReady,
    input  o_memAddr, o_memWData, o_memSize, o_memSign, o_memWrite, o_memEn,
    output i_memRData
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store initiator between the MEM stage and the unified memory data port.
// Latency: error 1, store 2, load 3 cycles to rspValid (split misaligned load 5).
// Backpressure: one request in flight; reqReady only in IDLE, response held until rspReady.
// Optional: define LSU_MISALIGN_SPLIT_EN to service misaligned half/word loads as two word reads.
module mem_lsu #(
  parameter int unsigned MEM_BYTES = 32768
) (
  input logic       i_clk,
  input logic       i_reset,
  mem_lsu_if.master io_bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    CAPT   = 3'd2,
`ifdef LSU_MISALIGN_SPLIT_EN
    ISSUE2 = 3'd3,
    CAPT2  = 3'd4,
`endif
    RESP   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;

  // request latches; the memory-side registers double as the address/data/size/sign latches
  logic        r_write;
  logic [31:0] r_memAddr;
  logic [31:0] r_memWData;
  logic [1:0]  r_memSize;
  logic        r_memSign;
  logic [31:0] r_rspData;
  logic        r_rspErr;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic        r_split;
  logic [1:0]  r_shift;
  logic [1:0]  r_size;
  logic [31:0] r_lo;
  logic [63:0] w_pair;
  logic [31:0] w_shifted;
  logic [31:0] w_merged;
`endif

  // request decode
  logic [32:0] w_reqLast;
  logic        w_misalign;
  logic        w_split;
  logic        w_rangeErr;
  logic        w_reqErr;
  logic [31:0] w_firstAddr;
  logic [1:0]  w_firstSize;
  logic        w_accept;

  assign w_accept = (r_state == IDLE) && io_bus.i_reqValid;

  // classify the incoming request: alignment, range and first memory access shape
  always_comb begin
    w_misalign  = ((io_bus.i_reqSize == 2'b01) && io_bus.i_reqAddr[0]) ||
                  ((io_bus.i_reqSize == 2'b10) && (io_bus.i_reqAddr[1:0] != 2'b00));
    w_split     = 1'b0;
    w_firstAddr = io_bus.i_reqAddr;
    w_firstSize = io_bus.i_reqSize;
    // last byte touched, in 33 bits so an access near 2^32 cannot wrap into range
    case (io_bus.i_reqSize)
      2'b00:   w_reqLast = {1'b0, io_bus.i_reqAddr};
      2'b01:   w_reqLast = {1'b0, io_bus.i_reqAddr} + 33'd1;
      default: w_reqLast = {1'b0, io_bus.i_reqAddr} + 33'd3;
    endcase
`ifdef LSU_MISALIGN_SPLIT_EN
    // misaligned loads read two aligned words; the range check must cover the upper word
    if (!io_bus.i_reqWrite && w_misalign) begin
      w_split     = 1'b1;
      w_firstAddr = {io_bus.i_reqAddr[31:2], 2'b00};
      w_firstSize = 2'b10;
      w_reqLast   = {1'b0, io_bus.i_reqAddr[31:2], 2'b00} + 33'd7;
    end
`endif
    w_rangeErr = (w_reqLast >= 33'(MEM_BYTES));
    w_reqErr   = (io_bus.i_reqSize == 2'b11) || (w_misalign && !w_split) || w_rangeErr;
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  // stitch the two captured words, shift the addressed bytes down, then extend
  always_comb begin
    w_pair    = {io_bus.i_memRData, r_lo};
    w_shifted = 32'(w_pair >> {r_shift, 3'b000});
    case (r_size)
      2'b01:   w_merged = r_memSign ? {16'h0000, w_shifted[15:0]}
                                    : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_merged = w_shifted;
    endcase
  end
`endif

  // state register; reset abandons any access in flight
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (io_bus.i_reqValid) begin
          w_next = w_reqErr ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        w_next = r_write ? RESP : CAPT;
      end
      CAPT: begin
`ifdef LSU_MISALIGN_SPLIT_EN
        w_next = r_split ? ISSUE2 : RESP;
`else
        w_next = RESP;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ISSUE2: w_next = CAPT2;
      CAPT2:  w_next = RESP;
`endif
      RESP: begin
        if (io_bus.i_rspReady) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // request latching, memory port registers and response capture
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_write    <= 1'b0;
      r_memAddr  <= 32'h0;
      r_memWData <= 32'h0;
      r_memSize  <= 2'b00;
      r_memSign  <= 1'b0;
      r_rspData  <= 32'h0;
      r_rspErr   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_split    <= 1'b0;
      r_shift    <= 2'b00;
      r_size     <= 2'b00;
      r_lo       <= 32'h0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write   <= io_bus.i_reqWrite;
            r_rspErr  <= w_reqErr;
            r_rspData <= 32'h0;
            // rejected requests leave the memory port untouched
            if (!w_reqErr) begin
              r_memAddr  <= w_firstAddr;
              r_memWData <= io_bus.i_reqWData;
              r_memSize  <= w_firstSize;
              r_memSign  <= io_bus.i_reqSign;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            r_split <= w_split;
            r_shift <= io_bus.i_reqAddr[1:0];
            r_size  <= io_bus.i_reqSize;
`endif
          end
        end
        CAPT: begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (r_split) begin
            r_lo      <= io_bus.i_memRData;
            r_memAddr <= r_memAddr + 32'd4;
          end else begin
            r_rspData <= io_bus.i_memRData;
          end
`else
          r_rspData <= io_bus.i_memRData;
`endif
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        CAPT2: begin
          r_rspData <= w_merged;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  assign io_bus.o_memEn = (r_state == ISSUE) || (r_state == ISSUE2);
`else
  assign io_bus.o_memEn = (r_state == ISSUE);
`endif
  assign io_bus.o_memWrite = (r_state == ISSUE) && r_write;
  assign io_bus.o_memAddr  = r_memAddr;
  assign io_bus.o_memWData = r_memWData;
  assign io_bus.o_memSize  = r_memSize;
  assign io_bus.o_memSign  = r_memSign;
  assign io_bus.o_reqReady = (r_state == IDLE);
  assign io_bus.o_rspValid = (r_state == RESP);
  assign io_bus.o_rspData  = r_rspData;
  assign io_bus.o_rspErr   = r_rspErr;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: memory model, request-level reference model, directed + random.
// Latency: checked per transaction against the expected response cycle.
// Backpressure: exercises response stalls with a pending request and reset mid-load.
module tb_mem_lsu;
  localparam int MB = 32768;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_lsu_if bus();
  mem_lsu #(.MEM_BYTES(MB)) dut (.i_clk(clk), .i_reset(rst), .io_bus(bus));

  int checks   = 0;
  int failures = 0;

  logic [7:0]  env_mem [0:MB-1];
  logic [7:0]  ref_mem [0:MB-1];
  int          acc_cnt = 0;
  logic [31:0] last_acc_addr = 32'h0;
  bit          pend = 1'b0;
  logic [31:0] pend_dat = 32'h0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // n little-endian bytes from either memory image, extended (zext=1 means zero-extend)
  function automatic logic [31:0] rd_bytes(input bit from_env, input logic [31:0] a, input int n,
                                          input logic zext);
    logic [31:0] v;
    logic [31:0] ai;
    logic [7:0]  b;
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      b  = from_env ? env_mem[ai[14:0]] : ref_mem[ai[14:0]];
      v  = v | ({24'h0, b} << (8 * i));
    end
    if (!zext && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
    return v;
  endfunction

  // unified memory: writes at the enable cycle, formatted read data valid the following cycle
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
      bus.i_memRData = 32'h0;
    end else begin
      bus.i_memRData = pend ? pend_dat : $urandom;
      pend = 1'b0;
      if (bus.o_memEn) begin
        acc_cnt++;
        last_acc_addr = bus.o_memAddr;
        if (bus.o_memWrite) begin
          for (int i = 0; i < (1 << bus.o_memSize); i++) begin
            logic [31:0] wa;
            wa = bus.o_memAddr + 32'(i);
            env_mem[wa[14:0]] = 8'(bus.o_memWData >> (8 * i));
          end
        end else begin
          pend     = 1'b1;
          pend_dat = rd_bytes(1'b1, bus.o_memAddr, 1 << bus.o_memSize, bus.o_memSign);
        end
      end
    end
  end

  // one request/response transaction, starting and ending at a negedge
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                     input logic sg, input logic wr, input int hold, input bit pre_next,
                     input bit expect_immediate, input bit use_lit,
                     input logic [31:0] lit_dat, input logic lit_err);
    int          n, lat, nacc, w, acc0;
    logic        mis, split, err;
    logic [32:0] last;
    logic [31:0] exp_dat, exp_addr;

    n     = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mis   = (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    split = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    split = mis && !wr;
`endif
    if (split) last = {1'b0, a[31:2], 2'b00} + 33'd7;
    else       last = {1'b0, a} + 33'(n) - 33'd1;
    err      = (sz == 2'b11) || (mis && !split) || (last >= 33'(MB));
    lat      = err ? 1 : wr ? 2 : split ? 5 : 3;
    nacc     = err ? 0 : split ? 2 : 1;
    exp_addr = split ? ({a[31:2], 2'b00} + 32'd4) : a;
    exp_dat  = (err || wr) ? 32'h0 : rd_bytes(1'b0, a, n, sg);
    if (!err && wr) begin
      for (int i = 0; i < n; i++) begin
        logic [31:0] ra;
        ra = a + 32'(i);
        ref_mem[ra[14:0]] = 8'(wd >> (8 * i));
      end
    end
    if (use_lit) begin
      chk32("lit_data", exp_dat, lit_dat);
      chk1("lit_err", err, lit_err);
    end

    bus.i_reqAddr  = a;
    bus.i_reqWData = wd;
    bus.i_reqSize  = sz;
    bus.i_reqSign  = sg;
    bus.i_reqWrite = wr;
    bus.i_reqValid = 1'b1;
    bus.i_rspReady = 1'b0;
    if (expect_immediate) chk1("ready_after_handshake", bus.o_reqReady, 1'b1);
    w = 0;
    while (!bus.o_reqReady && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.o_reqReady) begin
      chk1("accept_timeout", bus.o_reqReady, 1'b1);
      bus.i_reqValid = 1'b0;
      return;
    end
    @(posedge clk);
    acc0 = acc_cnt;
    @(negedge clk);
    bus.i_reqValid = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      chk1("rsp_valid_timing", bus.o_rspValid, (k == lat) ? 1'b1 : 1'b0);
      chk1("req_ready_busy", bus.o_reqReady, 1'b0);
      if (!bus.o_memEn) chk1("mem_write_idle", bus.o_memWrite, 1'b0);
      if (k < lat) @(negedge clk);
    end
    chk32("rsp_data", bus.o_rspData, exp_dat);
    chk1("rsp_err", bus.o_rspErr, err);
    for (int h = 0; h < hold; h++) begin
      if (pre_next) bus.i_reqValid = 1'b1;
      @(negedge clk);
      chk1("hold_valid", bus.o_rspValid, 1'b1);
      chk32("hold_data", bus.o_rspData, exp_dat);
      chk1("hold_ready", bus.o_reqReady, 1'b0);
      chk1("hold_no_access", bus.o_memEn, 1'b0);
    end
    bus.i_rspReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_rspReady = 1'b0;
    chk1("idle_after_rsp", bus.o_reqReady, 1'b1);
    chk1("rsp_dropped", bus.o_rspValid, 1'b0);
    chk32("access_count", 32'(acc_cnt - acc0), 32'(nacc));
    if (nacc > 0) chk32("access_addr", last_acc_addr, exp_addr);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] ra;
    logic [1:0]  rs;
    int          sel;
    for (int i = 0; i < MB; i++) begin
      env_mem[i] = 8'($urandom);
      ref_mem[i] = env_mem[i];
    end
    bus.i_reqValid = 1'b0;
    bus.i_reqAddr  = 32'h0;
    bus.i_reqWData = 32'h0;
    bus.i_reqSize  = 2'b00;
    bus.i_reqSign  = 1'b0;
    bus.i_reqWrite = 1'b0;
    bus.i_rspReady = 1'b0;
    repeat (3) @(negedge clk);
    chk1("reset_req_ready", bus.o_reqReady, 1'b1);
    chk1("reset_rsp_valid", bus.o_rspValid, 1'b0);
    chk1("reset_mem_en", bus.o_memEn, 1'b0);
    chk1("reset_mem_write", bus.o_memWrite, 1'b0);
    chk32("reset_mem_addr", bus.o_memAddr, 32'h0);
    chk32("reset_mem_wdata", bus.o_memWData, 32'h0);
    chk32("reset_rsp_data", bus.o_rspData, 32'h0);
    chk1("reset_rsp_err", bus.o_rspErr, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // directed: word store/load, byte sign handling, misaligned, range, reserved size
    txn(32'h100, 32'hDEADBEEF, 2'b10, 1'b0, 1'b1, 0, 0, 0, 1, 32'h0, 1'b0);
    txn(32'h100, 32'h0, 2'b10, 1'b0, 1'b0, 0, 0, 0, 1, 32'hDEADBEEF, 1'b0);
    txn(32'h103, 32'h80, 2'b00, 1'b0, 1'b1, 0, 0, 0, 1, 32'h0, 1'b0);
    txn(32'h103, 32'h0, 2'b00, 1'b0, 1'b0, 0, 0, 0, 1, 32'hFFFFFF80, 1'b0);
    txn(32'h103, 32'h0, 2'b00, 1'b1, 1'b0, 0, 0, 0, 1, 32'h00000080, 1'b0);
    txn(32'h100, 32'h11223344, 2'b10, 1'b0, 1'b1, 0, 0, 0, 1, 32'h0, 1'b0);
    txn(32'h104, 32'h55667788, 2'b10, 1'b0, 1'b1, 0, 0, 0, 1, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_SPLIT_EN
    txn(32'h102, 32'h0, 2'b10, 1'b0, 1'b0, 0, 0, 0, 1, 32'h77881122, 1'b0);
`else
    txn(32'h102, 32'h0, 2'b10, 1'b0, 1'b0, 0, 0, 0, 1, 32'h0, 1'b1);
`endif
    txn(32'h102, 32'h0, 2'b10, 1'b0, 1'b1, 0, 0, 0, 1, 32'h0, 1'b1);
    txn(32'h8000, 32'h0, 2'b10, 1'b0, 1'b0, 0, 0, 0, 1, 32'h0, 1'b1);
    txn(32'h7FFE, 32'h0, 2'b10, 1'b0, 1'b0, 0, 0, 0, 1, 32'h0, 1'b1);
    txn(32'h7FFF, 32'h0, 2'b00, 1'b1, 1'b0, 0, 0, 0, 0, 32'h0, 1'b0);
    txn(32'h0, 32'h0, 2'b11, 1'b0, 1'b0, 0, 0, 0, 1, 32'h0, 1'b1);

    // response stall with a pending request, then immediate acceptance
    txn(32'h100, 32'h0, 2'b10, 1'b0, 1'b0, 4, 1, 0, 1, 32'h11223344, 1'b0);
    txn(32'h104, 32'h0, 2'b01, 1'b1, 1'b0, 0, 0, 1, 1, 32'h00007788, 1'b0);

    // reset during CAPT of a load
    bus.i_reqAddr  = 32'h100;
    bus.i_reqSize  = 2'b10;
    bus.i_reqWrite = 1'b0;
    bus.i_reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_reqValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("rst_mem_en", bus.o_memEn, 1'b0);
    chk1("rst_rsp_valid", bus.o_rspValid, 1'b0);
    chk1("rst_req_ready", bus.o_reqReady, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_ready", bus.o_reqReady, 1'b1);
    txn(32'h100, 32'h0, 2'b10, 1'b0, 1'b0, 0, 0, 1, 1, 32'h11223344, 1'b0);

    // randomized traffic
    for (int t = 0; t < 80; t++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 70)      ra = 32'h100 + 32'($urandom_range(0, 63));
      else if (sel < 88) ra = 32'h7FF0 + 32'($urandom_range(0, 31));
      else               ra = $urandom;
      rs = 2'($urandom_range(0, 3));
      txn(ra, $urandom, rs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), 0, 0, 0, 32'h0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
